wave_display_reader: RTL and testbench
======================================

# wave_display_reader

Read side of the 512-entry ping-pong waveform RAM. While the capture side fills one 256-sample half, this block walks the other half in step with the VGA raster and turns each stored 8-bit sample into lit pixels, joining adjacent samples with vertical line segments. It sits between the VGA timing generator and the pixel mux. It drives `wave_display_idle` back to the capture side, which swaps halves only while that signal is high.

## Interface
Parameters:
- `WAVE_COLOR`, default 24'hFFFFFF: RGB value for lit waveform pixels.
- `BG_COLOR`, default 24'h000000: RGB value for unlit pixels inside the window.

Ports:
- `clk` in 1: single system clock.
- `reset` in 1: synchronous, active-low; asserted when 0, sampled on the rising `clk` edge.
- `x` in 11: raster column from VGA timing.
- `y` in 10: raster row from VGA timing.
- `valid` in 1: high when `x`/`y` are inside the visible area.
- `read_index` in 1: half most recently completed by the capture side.
- `read_address` out 9: RAM read address.
- `read_value` in 8: RAM data, synchronous read, 1-cycle latency.
- `valid_pixel` out 1: high when `r`/`g`/`b` belong to the waveform window.
- `r`, `g`, `b` out 8 each: pixel colour.
- `wave_display_idle` out 1: high when the reader is outside the window and a swap is safe.

## Operation
- Window: `valid` && `x[10:9]`==2'b01 && `y[9]`==0, i.e. x 512–1023, y 0–511. Each sample spans 2 columns (`x[8:1]`) and 2 rows (`y[8:1]`).
- `active_index` register loads `read_index` on every cycle where `wave_display_idle` is high and holds otherwise. This freezes the buffer for the whole window.
- `read_address` is registered: {`active_index`, `x[8:1]`}, updated every cycle.
- Sample mapping: stored value `s` is offset binary with 8'h80 as zero. Screen row is `h = 8'hFF - s`, so larger samples are drawn higher.
- `cur_h` and `prev_h` (8 bits each): when the column index changes and the pipeline is in-window, set `prev_h` to the old `cur_h` and `cur_h` to the new `h`.
  - First column of the window (`x[8:1]`==0): `prev_h` is set to the new `h`, so no segment is drawn from the previous line.
- Lit pixel: in-window && `y[8:1]` is between `min(prev_h,cur_h)` and `max(prev_h,cur_h)`, inclusive. The comparison is 8-bit unsigned with no wrap.
- Outputs:
  - In-window: `valid_pixel`=1, colour = `WAVE_COLOR` if lit, else `BG_COLOR`.
  - Out-of-window: `valid_pixel`=0, `r`/`g`/`b`=0.
- `wave_display_idle` = registered !(`valid` && `y[9]`==0). It is low for the entire top half of the visible frame, including columns outside the window.

## Timing
- Pipeline, three stages:
  - S0: register `x`/`y`/`valid`/in-window flag and `read_address`.
  - S1: RAM returns `read_value`; update `cur_h`/`prev_h`.
  - S2: compare and drive registered outputs.
- Latency: `x`/`y`/`valid` to `valid_pixel`/`r`/`g`/`b` is exactly 3 cycles, fixed, no stalls. The timing generator delays hsync/vsync by the same 3 cycles.
- `wave_display_idle` is one cycle after its inputs.
- `read_index` toggling while idle is low has no effect until idle rises; toggling while idle is high takes effect on the next cycle's address.
- Reset (`reset`==0), applied at any time including mid-window:
  - Next edge sets `read_address`=0, `active_index`=0, `cur_h`=`prev_h`=0, `valid_pixel`=0, `r`/`g`/`b`=0, `wave_display_idle`=1.
  - All pipeline valid flags are cleared, so stale stages produce no in-window pixels during the 3 cycles after release.

## Structure
- Shared package/header holds the window bounds (X_BASE=512, Y_LIMIT=512), pipeline depth 3, and the 8'h80 midpoint, shared with `wave_capture` and the top level.
- One natural sub-module: `wave_seg_compare`, combinational min/max and inclusive-range test on 8-bit values.
- All state lives in `dffr`/`dffre` instances, consistent with the rest of the design.

## Test plan
- Reset mid-window: hold `reset`=0 for 2 cycles with `x`=600, `y`=100 -> `valid_pixel`=0, rgb=0, `wave_display_idle`=1, `read_address`=0; 3 cycles after release, outputs track the raster normally.
- Flat line: RAM half 1 all 8'h80, `read_index`=1 latched during idle, scan row `y`=254 (`y[8:1]`=127) -> every in-window pixel is `WAVE_COLOR`; at `y`=252, every in-window pixel is `BG_COLOR`; `read_address[8]`=1 throughout.
- Segment: samples 8'h80 at address 10 and 8'h90 at address 11, x=534/535 -> rows with `y[8:1]` from 111 to 127 are lit; 110 and 128 are not.
- Latency and address: step `x` from 511 to 512 with `valid`=1 -> `read_address`={idx,8'h00} one cycle later; `valid_pixel` rises exactly 3 cycles after the step.
- Buffer freeze: toggle `read_index` at y=200 (idle low) -> `read_address[8]` unchanged until `y` reaches 512 and idle rises, then follows the new value.
- First column: address 255 holds 8'h00 and address 0 holds 8'hFF at x=512 -> only `y[8:1]`==0 is lit in column 0; no segment is drawn from sample 255.

Source files
------------

// File: rtl/wave_display_reader_pkg.sv
// Shared window geometry, pipeline depth and sample encoding for the waveform
// capture/display path.
package wave_display_reader_pkg;

  localparam logic [10:0] X_BASE     = 11'd512;
  localparam logic [10:0] X_END      = 11'd1024;
  localparam logic [9:0]  Y_LIMIT    = 10'd512;
  localparam int unsigned PIPE_DEPTH = 3;
  localparam logic [7:0]  SAMPLE_MID = 8'h80;

  typedef struct packed {
    logic       win;
    logic [7:0] col;
    logic [7:0] row;
  } stage_t;

  // Offset-binary sample to screen row; the zero level lands on row 127.
  function automatic logic [7:0] sample_to_row(input logic [7:0] s);
    return (SAMPLE_MID - 8'd1) + (SAMPLE_MID - s);
  endfunction

  function automatic logic in_window(input logic [10:0] xv, input logic [9:0] yv,
                                     input logic v);
    return v && (xv >= X_BASE) && (xv < X_END) && (yv < Y_LIMIT);
  endfunction

endpackage

// File: rtl/wave_display_reader_dffr.sv
// Flip-flop primitives with synchronous active-low reset; dffre adds a load enable.
module dffr #(
  parameter int unsigned W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      q_o <= RST_VAL;
    end else begin
      q_o <= d_i;
    end
  end

endmodule

module dffre #(
  parameter int unsigned W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      q_o <= RST_VAL;
    end else if (en_i) begin
      q_o <= d_i;
    end else begin
      q_o <= q_o;
    end
  end

endmodule

// File: rtl/wave_display_reader_seg_compare.sv
// Inclusive range test of v against the span between two 8-bit rows, in either order.
module wave_seg_compare (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic [7:0] v_i,
  output logic       hit_o
);

  logic [7:0] lo_s;
  logic [7:0] hi_s;

  always_comb begin
    lo_s = a_i;
    hi_s = b_i;
    if (a_i < b_i) begin
      lo_s = a_i;
      hi_s = b_i;
    end else begin
      lo_s = b_i;
      hi_s = a_i;
    end
    hit_o = (v_i >= lo_s) && (v_i <= hi_s);
  end

endmodule

// File: rtl/wave_display_reader.sv
// Read side of the ping-pong waveform RAM: walks the frozen half in raster order
// and draws each sample joined to its left neighbour by a vertical segment.
module wave_display_reader
  import wave_display_reader_pkg::*;
#(
  parameter logic [23:0] WAVE_COLOR = 24'hFFFFFF,
  parameter logic [23:0] BG_COLOR   = 24'h000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] x,
  input  logic [9:0]  y,
  input  logic        valid,
  input  logic        read_index,
  output logic [8:0]  read_address,
  input  logic [7:0]  read_value,
  output logic        valid_pixel,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        wave_display_idle
);

  localparam int unsigned NSTAGE = PIPE_DEPTH - 1;

  logic        idle_d, idle_q;
  logic        active_index_q;
  logic [8:0]  read_address_d, read_address_q;
  stage_t      s0_d;
  stage_t      s1;
  stage_t      stage_in [NSTAGE];
  stage_t      stage_q  [NSTAGE];
  logic        last_win_q;
  logic [7:0]  last_col_q;
  logic [7:0]  h_s;
  logic [7:0]  cur_d, cur_q, prev_d, prev_q;
  logic        col_step_s;
  logic        lit_s;
  logic        valid_pixel_d, valid_pixel_q;
  logic [23:0] rgb_d, rgb_q;

  assign s0_d           = '{win: in_window(x, y, valid), col: x[8:1], row: y[8:1]};
  assign idle_d         = !(valid && (y < Y_LIMIT));
  assign read_address_d = {active_index_q, x[8:1]};

  dffr #(.W(1), .RST_VAL(1'b1)) u_idle (
    .clk_i(clk), .rst_ni(reset), .d_i(idle_d), .q_o(idle_q)
  );

  // The half only changes while the raster is outside the top half of the frame.
  dffre #(.W(1), .RST_VAL(1'b0)) u_active_index (
    .clk_i(clk), .rst_ni(reset), .en_i(idle_q), .d_i(read_index), .q_o(active_index_q)
  );

  dffr #(.W(9), .RST_VAL(9'd0)) u_read_address (
    .clk_i(clk), .rst_ni(reset), .d_i(read_address_d), .q_o(read_address_q)
  );

  for (genvar i = 0; i < NSTAGE; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign stage_in[i] = s0_d;
    end else begin : g_tail
      assign stage_in[i] = stage_q[i-1];
    end
    dffr #(.W($bits(stage_t)), .RST_VAL('0)) u_stage (
      .clk_i(clk), .rst_ni(reset), .d_i(stage_in[i]), .q_o(stage_q[i])
    );
  end

  // The last stage lines up with the RAM data for the address it issued.
  assign s1  = stage_q[NSTAGE-1];
  assign h_s = sample_to_row(read_value);

  // Advance the sample history on entry to a new column; column 0 starts a fresh trace.
  always_comb begin
    cur_d      = cur_q;
    prev_d     = prev_q;
    col_step_s = s1.win && (!last_win_q || (s1.col != last_col_q));
    if (col_step_s) begin
      cur_d = h_s;
      if (s1.col == 8'd0) begin
        prev_d = h_s;
      end else begin
        prev_d = cur_q;
      end
    end else begin
      cur_d  = cur_q;
      prev_d = prev_q;
    end
  end

  dffr #(.W(1), .RST_VAL(1'b0)) u_last_win (
    .clk_i(clk), .rst_ni(reset), .d_i(s1.win), .q_o(last_win_q)
  );
  dffr #(.W(8), .RST_VAL(8'd0)) u_last_col (
    .clk_i(clk), .rst_ni(reset), .d_i(s1.col), .q_o(last_col_q)
  );
  dffr #(.W(8), .RST_VAL(8'd0)) u_cur_h (
    .clk_i(clk), .rst_ni(reset), .d_i(cur_d), .q_o(cur_q)
  );
  dffr #(.W(8), .RST_VAL(8'd0)) u_prev_h (
    .clk_i(clk), .rst_ni(reset), .d_i(prev_d), .q_o(prev_q)
  );

  wave_seg_compare u_seg (
    .a_i  (prev_d),
    .b_i  (cur_d),
    .v_i  (s1.row),
    .hit_o(lit_s)
  );

  always_comb begin
    valid_pixel_d = s1.win;
    rgb_d         = 24'h000000;
    if (s1.win) begin
      if (lit_s) begin
        rgb_d = WAVE_COLOR;
      end else begin
        rgb_d = BG_COLOR;
      end
    end else begin
      rgb_d = 24'h000000;
    end
  end

  dffr #(.W(1), .RST_VAL(1'b0)) u_valid_pixel (
    .clk_i(clk), .rst_ni(reset), .d_i(valid_pixel_d), .q_o(valid_pixel_q)
  );
  dffr #(.W(24), .RST_VAL(24'h000000)) u_rgb (
    .clk_i(clk), .rst_ni(reset), .d_i(rgb_d), .q_o(rgb_q)
  );

  assign read_address      = read_address_q;
  assign valid_pixel       = valid_pixel_q;
  assign r                 = rgb_q[23:16];
  assign g                 = rgb_q[15:8];
  assign b                 = rgb_q[7:0];
  assign wave_display_idle = idle_q;

endmodule

// File: tb/tb_wave_display_reader.sv
// Self-checking bench: randomized raster traffic against a sample-level reference
// model, plus directed scenarios with hand-computed expectations.
module tb_wave_display_reader;

  localparam logic [23:0] WAVE_C = 24'hE0A050;
  localparam logic [23:0] BG_C   = 24'h102030;

  logic        clk;
  logic        reset;
  logic [10:0] x;
  logic [9:0]  y;
  logic        valid;
  logic        read_index;
  logic [8:0]  read_address;
  logic [7:0]  read_value;
  logic        valid_pixel;
  logic [7:0]  r, g, b;
  logic        wave_display_idle;

  logic [7:0]  mem [0:511];
  logic [7:0]  ram_q;

  int n_checks = 0;
  int n_err    = 0;

  wave_display_reader #(.WAVE_COLOR(WAVE_C), .BG_COLOR(BG_C)) dut (
    .clk              (clk),
    .reset            (reset),
    .x                (x),
    .y                (y),
    .valid            (valid),
    .read_index       (read_index),
    .read_address     (read_address),
    .read_value       (read_value),
    .valid_pixel      (valid_pixel),
    .r                (r),
    .g                (g),
    .b                (b),
    .wave_display_idle(wave_display_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM, one cycle of latency.
  always @(posedge clk) ram_q <= mem[read_address];
  assign read_value = ram_q;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit win;
    int col;
    int row;
    int addr;
  } ent_t;

  ent_t        pipe_m[$];
  bit          m_ready = 1'b0;
  bit          m_idle, m_act, m_lastwin;
  int          m_cur, m_prev, m_lastcol;
  int          e_addr;
  bit          e_idle, e_vp;
  logic [23:0] e_rgb;

  always @(posedge clk) begin
    ent_t e, o, inv;
    int   h, lo, hi;
    bit   lit;
    inv = '{win: 1'b0, col: 0, row: 0, addr: 0};
    if (!reset) begin
      m_idle = 1'b1; m_act = 1'b0; m_cur = 0; m_prev = 0;
      m_lastwin = 1'b0; m_lastcol = 0;
      e_addr = 0; e_idle = 1'b1; e_vp = 1'b0; e_rgb = 24'h0;
      pipe_m.delete();
      pipe_m.push_back(inv);
      pipe_m.push_back(inv);
      m_ready = 1'b1;
    end else begin
      e.win  = valid && (x >= 512) && (x < 1024) && (y < 512);
      e.col  = (int'(x) / 2) % 256;
      e.row  = (int'(y) / 2) % 256;
      e.addr = int'(m_act) * 256 + e.col;
      e_addr = e.addr;
      if (m_idle) m_act = read_index;
      m_idle = !(valid && (y < 512));
      e_idle = m_idle;
      pipe_m.push_back(e);
      o = pipe_m.pop_front();
      if (o.win && (!m_lastwin || o.col != m_lastcol)) begin
        h = 255 - int'(mem[o.addr]);
        m_prev = (o.col == 0) ? h : m_cur;
        m_cur  = h;
      end
      m_lastwin = o.win;
      m_lastcol = o.col;
      lo  = (m_prev < m_cur) ? m_prev : m_cur;
      hi  = (m_prev < m_cur) ? m_cur : m_prev;
      lit = o.win && (o.row >= lo) && (o.row <= hi);
      e_vp  = o.win;
      e_rgb = !o.win ? 24'h0 : (lit ? WAVE_C : BG_C);
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (m_ready) begin
      chk("read_address", 32'(read_address), 32'(e_addr));
      chk("idle", 32'(wave_display_idle), 32'(e_idle));
      chk("valid_pixel", 32'(valid_pixel), 32'(e_vp));
      chk("rgb", 32'({r, g, b}), 32'(e_rgb));
    end
  end

  // ---------------- stimulus ----------------
  task automatic hold(input int xv, input int yv, input bit vv, input int n);
    for (int i = 0; i < n; i++) begin
      x = xv[10:0]; y = yv[9:0]; valid = vv;
      @(posedge clk); #1;
    end
  endtask

  task automatic scan_row(input int yv);
    for (int xv = 500; xv < 1030; xv++) hold(xv, yv, 1'b1, 1);
  endtask

  initial begin
    x = 11'd0; y = 10'd0; valid = 1'b0; read_index = 1'b0; reset = 1'b0;
    for (int a = 0; a < 512; a++) mem[a] = 8'($urandom);
    hold(0, 600, 1'b0, 3);
    reset = 1'b1;
    hold(0, 600, 1'b0, 3);

    // Reset in the middle of the window
    hold(600, 100, 1'b1, 4);
    reset = 1'b0;
    hold(600, 100, 1'b1, 1);
    chk("rst_vp", 32'(valid_pixel), 32'd0);
    chk("rst_rgb", 32'({r, g, b}), 32'd0);
    chk("rst_idle", 32'(wave_display_idle), 32'd1);
    chk("rst_addr", 32'(read_address), 32'd0);
    hold(600, 100, 1'b1, 1);
    chk("rst_vp2", 32'(valid_pixel), 32'd0);
    reset = 1'b1;
    hold(600, 100, 1'b1, 2);
    chk("rel_vp_stale", 32'(valid_pixel), 32'd0);
    hold(600, 100, 1'b1, 1);
    chk("rel_vp_on", 32'(valid_pixel), 32'd1);

    // Flat line at the zero level in half 1
    for (int a = 256; a < 512; a++) mem[a] = 8'h80;
    read_index = 1'b1;
    hold(0, 600, 1'b0, 4);
    scan_row(254);
    scan_row(252);
    hold(700, 254, 1'b1, 4);
    chk("flat_vp", 32'(valid_pixel), 32'd1);
    chk("flat_lit", 32'({r, g, b}), 32'(WAVE_C));
    chk("flat_addr", 32'(read_address), 32'd350);
    hold(700, 252, 1'b1, 4);
    chk("flat_bg", 32'({r, g, b}), 32'(BG_C));

    // Segment between address 10 (0x80) and 11 (0x90)
    hold(0, 600, 1'b0, 4);
    mem[256 + 11] = 8'h90;
    foreach (mem[a]) if (a == 256 + 10) mem[a] = 8'h80;
    for (int k = 0; k < 4; k++) begin
      int  yv;
      bit  on;
      yv = (k == 0) ? 220 : (k == 1) ? 222 : (k == 2) ? 254 : 256;
      on = (k == 1) || (k == 2);
      hold(532, yv, 1'b1, 2);
      hold(534, yv, 1'b1, 4);
      chk("seg_vp", 32'(valid_pixel), 32'd1);
      chk("seg_rgb", 32'({r, g, b}), on ? 32'(WAVE_C) : 32'(BG_C));
    end
    scan_row(230);

    // Latency and address on entering the window
    hold(511, 300, 1'b1, 2);
    x = 11'd512; y = 10'd300; valid = 1'b1;
    @(posedge clk); #1;
    chk("lat_addr", 32'(read_address), 32'h100);
    chk("lat_vp1", 32'(valid_pixel), 32'd0);
    @(posedge clk); #1;
    chk("lat_vp2", 32'(valid_pixel), 32'd0);
    @(posedge clk); #1;
    chk("lat_vp3", 32'(valid_pixel), 32'd1);

    // Buffer freeze while idle is low
    hold(600, 200, 1'b1, 2);
    read_index = 1'b0;
    hold(600, 200, 1'b1, 3);
    chk("freeze_addr", 32'(read_address), 32'd300);
    hold(600, 512, 1'b1, 3);
    chk("swap_addr", 32'(read_address), 32'd44);
    chk("swap_idle", 32'(wave_display_idle), 32'd1);

    // First column does not join to the previous line's last sample
    hold(0, 600, 1'b0, 4);
    mem[255] = 8'h00;
    mem[0]   = 8'hFF;
    hold(1022, 2, 1'b1, 2);
    hold(512, 2, 1'b1, 4);
    chk("col0_row1", 32'({r, g, b}), 32'(BG_C));
    hold(1022, 0, 1'b1, 2);
    hold(512, 0, 1'b1, 4);
    chk("col0_row0", 32'({r, g, b}), 32'(WAVE_C));
    scan_row(2);

    // Randomized raster traffic
    for (int it = 0; it < 24; it++) begin
      int yv;
      if (it % 6 == 0) begin
        hold(0, 600, 1'b0, 4);
        for (int a = 0; a < 512; a++) mem[a] = 8'($urandom);
      end
      read_index = 1'($urandom);
      yv = int'($urandom_range(0, 600));
      for (int xv = int'($urandom_range(480, 520)); xv < 1040; xv++) begin
        hold(xv, yv, ($urandom_range(0, 15) != 0), 1);
        if ($urandom_range(0, 63) == 0) read_index = ~read_index;
      end
      if ($urandom_range(0, 3) == 0) begin
        reset = 1'b0;
        hold(int'($urandom_range(512, 1023)), int'($urandom_range(0, 511)), 1'b1,
             int'($urandom_range(1, 2)));
        reset = 1'b1;
      end
    end
    for (int i = 0; i < 400; i++) begin
      read_index = 1'($urandom);
      hold(int'($urandom_range(0, 2047)), int'($urandom_range(0, 1023)), 1'($urandom), 1);
    end
    hold(0, 600, 1'b0, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
